// File: rtl/cheshire_eoc_monitor_if.sv
// Signal bundle between an EOC driver (harts / preload agents) and the monitor.
interface cheshire_eoc_monitor_if #(
   parameter int unsigned NumChan   = 2,
   parameter int unsigned DataWidth = 32
) ();

   localparam int unsigned ChanWidth = (NumChan > 1) ? $clog2(NumChan) : 1;

   logic                           start_i;
   logic [NumChan-1:0]             wr_valid_i;
   logic [NumChan*DataWidth-1:0]   wr_data_i;

   logic                           busy_o;
   logic                           done_o;
   logic [NumChan-1:0]             chan_done_o;
   logic [DataWidth-2:0]           exit_code_o;
   logic [ChanWidth-1:0]           exit_chan_o;
   logic                           timeout_o;
   logic                           pass_o;

   modport master (
      output start_i, wr_valid_i, wr_data_i,
      input  busy_o, done_o, chan_done_o, exit_code_o, exit_chan_o, timeout_o, pass_o
   );

   modport slave (
      input  start_i, wr_valid_i, wr_data_i,
      output busy_o, done_o, chan_done_o, exit_code_o, exit_chan_o, timeout_o, pass_o
   );

endinterface

// File: rtl/cheshire_eoc_monitor.sv
// End-of-computation monitor: arms a set of EOC channels, waits for their exit
// writes (or a cycle timeout) and reports an aggregated exit code.
module cheshire_eoc_monitor #(
   parameter int unsigned NumChan       = 2,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 1000000,
   parameter bit          WaitAll       = 1'b1
) (
   input logic                   clk_i,
   input logic                   rst_i,
   cheshire_eoc_monitor_if.slave bus
);

   localparam int unsigned ChanWidth = (NumChan > 1) ? $clog2(NumChan) : 1;
   localparam int unsigned CodeWidth = DataWidth - 1;
   localparam int unsigned CntWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

   typedef enum logic [1:0] {
      CH_IDLE    = 2'd0,
      CH_ARMED   = 2'd1,
      CH_DONE    = 2'd2,
      CH_TIMEOUT = 2'd3
   } chan_state_e;

   typedef enum logic [1:0] {
      TOP_IDLE   = 2'd0,
      TOP_RUN    = 2'd1,
      TOP_FINISH = 2'd2
   } top_state_e;

   chan_state_e          chan_q    [NumChan];
   chan_state_e          chan_step [NumChan];
   chan_state_e          chan_d    [NumChan];
   logic [CodeWidth-1:0] code_q    [NumChan];
   logic [CodeWidth-1:0] code_d    [NumChan];

   top_state_e           top_q, top_d;
   logic [CntWidth-1:0]  cnt_q, cnt_d;

   logic                 done_q, done_d;
   logic                 timeout_q, timeout_d;
   logic                 pass_q, pass_d;
   logic [CodeWidth-1:0] exit_code_q, exit_code_d;
   logic [ChanWidth-1:0] exit_chan_q, exit_chan_d;

   logic                 arm;
   logic                 timeout_hit;
   logic                 any_armed;
   logic                 any_ended;
   logic                 finish;

   logic                 found_tmo, found_nz, found_done;
   logic [ChanWidth-1:0] tmo_idx, nz_idx, done_idx;
   logic [CodeWidth-1:0] nz_code;

   // A start request is only honoured outside of a running measurement.
   assign arm         = bus.start_i && (top_q != TOP_RUN);
   assign timeout_hit = (TimeoutCycles != 0) && (top_q == TOP_RUN) && (cnt_q == CntLast);

   // Per-channel transitions: arm, first valid EOC write, or forced timeout (write wins).
   always_comb begin
      for (int k = 0; k < NumChan; k++) begin
         chan_step[k] = chan_q[k];
         code_d[k]    = code_q[k];
         if (arm) begin
            chan_step[k] = CH_ARMED;
            code_d[k]    = '0;
         end else if ((top_q == TOP_RUN) && (chan_q[k] == CH_ARMED)) begin
            if (bus.wr_valid_i[k] && bus.wr_data_i[k*DataWidth]) begin
               chan_step[k] = CH_DONE;
               code_d[k]    = bus.wr_data_i[k*DataWidth+1 +: CodeWidth];
            end else if (timeout_hit) begin
               chan_step[k] = CH_TIMEOUT;
            end
         end
      end
   end

   // Finish decision on the channel states that will be visible next cycle.
   always_comb begin
      any_armed = 1'b0;
      any_ended = 1'b0;
      for (int k = 0; k < NumChan; k++) begin
         if (chan_step[k] == CH_ARMED) any_armed = 1'b1;
         if ((chan_step[k] == CH_DONE) || (chan_step[k] == CH_TIMEOUT)) any_ended = 1'b1;
      end
      finish = (top_q == TOP_RUN) && (WaitAll ? !any_armed : any_ended);
   end

   // In any-channel mode, channels still waiting at finish are released so late writes are dropped.
   always_comb begin
      for (int k = 0; k < NumChan; k++) begin
         chan_d[k] = chan_step[k];
         if (finish && !WaitAll && (chan_step[k] == CH_ARMED)) chan_d[k] = CH_IDLE;
      end
   end

   // Channel state and captured exit code registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NumChan; k++) begin
            chan_q[k] <= CH_IDLE;
            code_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NumChan; k++) begin
            chan_q[k] <= chan_d[k];
            code_q[k] <= code_d[k];
         end
      end
   end

   // Top-level state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) top_q <= TOP_IDLE;
      else       top_q <= top_d;
   end

   // Top-level next-state: a start arms, a finish ends, start during a run is ignored.
   always_comb begin
      top_d = top_q;
      case (top_q)
         TOP_IDLE:   if (bus.start_i) top_d = TOP_RUN;
         TOP_RUN:    if (finish)      top_d = TOP_FINISH;
         TOP_FINISH: if (bus.start_i) top_d = TOP_RUN;
         default:    top_d = TOP_IDLE;
      endcase
   end

   // Top-level outputs, all derived from registered state.
   always_comb begin
      bus.busy_o      = (top_q == TOP_RUN);
      bus.done_o      = done_q;
      bus.exit_code_o = exit_code_q;
      bus.exit_chan_o = exit_chan_q;
      bus.timeout_o   = timeout_q;
      bus.pass_o      = pass_q;
      bus.chan_done_o = '0;
      for (int k = 0; k < NumChan; k++) begin
         bus.chan_done_o[k] = (chan_q[k] == CH_DONE);
      end
   end

   // Saturating run-cycle counter, restarted on every arm.
   always_comb begin
      cnt_d = cnt_q;
      if (arm)                                   cnt_d = '0;
      else if ((top_q == TOP_RUN) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   // Lowest-index search for timed-out, nonzero-code and completed channels.
   always_comb begin
      found_tmo  = 1'b0;
      found_nz   = 1'b0;
      found_done = 1'b0;
      tmo_idx    = '0;
      nz_idx     = '0;
      done_idx   = '0;
      nz_code    = '0;
      for (int k = NumChan - 1; k >= 0; k--) begin
         if (chan_d[k] == CH_TIMEOUT) begin
            found_tmo = 1'b1;
            tmo_idx   = ChanWidth'(k);
         end
         if (chan_d[k] == CH_DONE) begin
            found_done = 1'b1;
            done_idx   = ChanWidth'(k);
            if (code_d[k] != '0) begin
               found_nz = 1'b1;
               nz_idx   = ChanWidth'(k);
               nz_code  = code_d[k];
            end
         end
      end
   end

   // Results are cleared on arm, computed once at finish and then held.
   always_comb begin
      done_d      = finish;
      exit_code_d = exit_code_q;
      exit_chan_d = exit_chan_q;
      timeout_d   = timeout_q;
      pass_d      = pass_q;
      if (arm) begin
         exit_code_d = '0;
         exit_chan_d = '0;
         timeout_d   = 1'b0;
         pass_d      = 1'b0;
      end else if (finish) begin
         if (found_tmo) begin
            exit_code_d = '1;
            exit_chan_d = tmo_idx;
            timeout_d   = 1'b1;
            pass_d      = 1'b0;
         end else if (found_nz) begin
            exit_code_d = nz_code;
            exit_chan_d = nz_idx;
            timeout_d   = 1'b0;
            pass_d      = 1'b0;
         end else begin
            exit_code_d = '0;
            exit_chan_d = found_done ? done_idx : '0;
            timeout_d   = 1'b0;
            pass_d      = 1'b1;
         end
      end
   end

   // Counter, done pulse and result registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         done_q      <= 1'b0;
         exit_code_q <= '0;
         exit_chan_q <= '0;
         timeout_q   <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         exit_code_q <= exit_code_d;
         exit_chan_q <= exit_chan_d;
         timeout_q   <= timeout_d;
         pass_q      <= pass_d;
      end
   end

endmodule
